// File: rtl/line_buffer_chain.sv
// Line buffer chain: KERNEL_LENGTH-1 row stores turn a raster pixel stream into column vectors.
// Optional macro LINE_BUFFER_DEBUG_EN adds dbg_col_cnt / dbg_row_cnt counter mirrors.
module line_buffer_chain #(
  parameter int DATA_WIDTH    = 32,
  parameter int ROW_LENGTH    = 32,
  parameter int KERNEL_LENGTH = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               din,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [KERNEL_LENGTH*DATA_WIDTH-1:0] dout,
  output logic                                out_eol,
`ifdef LINE_BUFFER_DEBUG_EN
  output logic [$clog2(ROW_LENGTH)-1:0]       dbg_col_cnt,
  output logic [$clog2(KERNEL_LENGTH)-1:0]    dbg_row_cnt,
`endif
  output logic                                full_flag
);

  localparam int CW = $clog2(ROW_LENGTH);
  localparam int RW = $clog2(KERNEL_LENGTH);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_LENGTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(KERNEL_LENGTH - 1);
  localparam logic [RW-1:0] ROW_PRE  = RW'(KERNEL_LENGTH - 2);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                                state;
  logic [CW-1:0]                         col_cnt;
  logic [RW-1:0]                         row_cnt;
  logic [DATA_WIDTH-1:0]                 store [KERNEL_LENGTH-1][ROW_LENGTH];
  logic [KERNEL_LENGTH*DATA_WIDTH-1:0]   candidate;
  logic                                  accept;
  logic                                  col_wrap;

  // Handshake: a pixel moves when in_valid && in_ready; a vector moves when
  // out_valid && out_ready. A held, untaken vector blocks new input.
  assign in_ready  = !clear && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_wrap  = (col_cnt == COL_LAST);
  assign full_flag = (state == STREAM);

  // Index 0 is the oldest row, the live pixel is the newest.
  always_comb begin
    candidate = '0;
    for (int i = 0; i < KERNEL_LENGTH - 1; i++)
      candidate[i*DATA_WIDTH +: DATA_WIDTH] = store[KERNEL_LENGTH-2-i][col_cnt];
    candidate[(KERNEL_LENGTH-1)*DATA_WIDTH +: DATA_WIDTH] = din;
  end

  // Row stores carry no reset; their contents only matter once refilled.
  always_ff @(posedge clk) begin
    if (accept) begin
      store[0][col_cnt] <= din;
      for (int j = 1; j < KERNEL_LENGTH - 1; j++)
        store[j][col_cnt] <= store[j-1][col_cnt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      dout      <= '0;
    end else if (clear) begin
      state     <= FILL;
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      if (accept) begin
        col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
        if (col_wrap && row_cnt != ROW_LAST)
          row_cnt <= row_cnt + 1'b1;
        if (col_wrap && row_cnt == ROW_PRE)
          state <= STREAM;
      end
      if (accept && state == STREAM) begin
        dout      <= candidate;
        out_valid <= 1'b1;
        out_eol   <= col_wrap;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_eol   <= 1'b0;
      end
    end
  end

`ifdef LINE_BUFFER_DEBUG_EN
  assign dbg_col_cnt = col_cnt;
  assign dbg_row_cnt = row_cnt;
`endif

endmodule

// File: tb/tb_line_buffer_chain.sv
// Bench for line_buffer_chain (K=3, ROW=4, 8-bit); reference model rebuilds vectors from the frame's pixel history.
module tb_line_buffer_chain;
  localparam int DW = 8;
  localparam int RL = 4;
  localparam int K  = 3;
  localparam int FILL_N = (K - 1) * RL;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   din;
  logic            out_valid;
  logic            out_ready;
  logic [K*DW-1:0] dout;
  logic            out_eol;
  logic            full_flag;
`ifdef LINE_BUFFER_DEBUG_EN
  logic [$clog2(RL)-1:0] dbg_col_cnt;
  logic [$clog2(K)-1:0]  dbg_row_cnt;
`endif

  line_buffer_chain #(.DATA_WIDTH(DW), .ROW_LENGTH(RL), .KERNEL_LENGTH(K)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_eol(out_eol),
`ifdef LINE_BUFFER_DEBUG_EN
    .dbg_col_cnt(dbg_col_cnt), .dbg_row_cnt(dbg_row_cnt),
`endif
    .full_flag(full_flag)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0]   frame[$];   // pixels accepted since the last frame restart
  logic [K*DW:0]   exp_q[$];   // expected vectors, MSB = eol

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic clr, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, output logic acc);
    logic          exp_ir;
    logic [K*DW:0] v;
    int            n;
    @(negedge clk);
    clear = clr; in_valid = iv; din = d; out_ready = ordy;
    #1;
    exp_ir = !clr && (exp_q.size() == 0 || ordy);
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("full_flag", 64'(full_flag), 64'(frame.size() >= FILL_N));
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    if (exp_q.size() != 0) begin
      check("dout", 64'(dout), 64'(exp_q[0][K*DW-1:0]));
      check("out_eol", 64'(out_eol), 64'(exp_q[0][K*DW]));
    end
    acc = iv && exp_ir;
    if (clr) begin
      exp_q.delete();
      frame.delete();
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (acc) begin
        frame.push_back(d);
        n = frame.size() - 1;
        if (n >= FILL_N) begin
          for (int i = 0; i < K; i++) v[i*DW +: DW] = frame[n - (K - 1 - i) * RL];
          v[K*DW] = ((n % RL) == RL - 1);
          exp_q.push_back(v);
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    int   p;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_full_flag", 64'(full_flag), 64'd0);
    check("rst_out_eol", 64'(out_eol), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill then stream pixels 0..11 with the consumer always ready
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, DW'(i), 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, acc);

    // Backpressure after the first streamed vector
    step(1'b1, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, DW'(i), 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, DW'(9), 1'b0, acc);
      check("bp_no_accept", 64'(acc), 64'd0);
    end
    p = 9;
    for (int i = 0; i < 8 && p < 12; i++) begin
      step(1'b0, 1'b1, DW'(p), 1'b1, acc);
      if (acc) p++;
    end
    check("bp_all_sent", 64'(p), 64'd12);
    step(1'b0, 1'b0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, acc);

    // Clear during pixel 9, then 8 pixels of refill with no output
    step(1'b1, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, DW'(i), 1'b1, acc);
    step(1'b1, 1'b1, DW'(9), 1'b1, acc);
    for (int i = 9; i < 17; i++) step(1'b0, 1'b1, DW'(i), 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, acc);

`ifdef LINE_BUFFER_DEBUG_EN
    step(1'b1, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, DW'(i), 1'b1, acc);
    #1;
    check("dbg_col_cnt", 64'(dbg_col_cnt), 64'd2);
    check("dbg_row_cnt", 64'(dbg_row_cnt), 64'd1);
`endif

    // Randomized traffic with occasional clears
    step(1'b1, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, DW'($urandom),
           $urandom_range(0, 3) != 0, acc);

    // Async reset between edges while an end-of-line vector is pending
    step(1'b1, 1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, DW'(i + 100), 1'b1, acc);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_full_flag", 64'(full_flag), 64'd0);
    check("arst_out_eol", 64'(out_eol), 64'd0);
    check("arst_dout", 64'(dout), 64'd0);
    exp_q.delete();
    frame.delete();
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, DW'(i + 50), 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/line_buffer_chain.md
LINE_BUFFER_CHAIN -- requirements
Module: line_buffer_chain

Interface
REQ-001 Parameter DATA_WIDTH, default 32, pixel width in bits.
REQ-002 Parameter ROW_LENGTH, default 32, pixels per image row; legal range 2..1024.
REQ-003 Parameter KERNEL_LENGTH, default 3, rows per output column vector; legal range 2..8.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 clear  input  1  synchronous frame restart.
REQ-007 in_valid  input  1  din holds a valid pixel.
REQ-008 in_ready  output  1  block accepts din this cycle.
REQ-009 din  input  DATA_WIDTH  pixel in raster order.
REQ-010 out_valid  output  1  dout holds a valid column vector.
REQ-011 out_ready  input  1  consumer takes dout this cycle.
REQ-012 dout  output  KERNEL_LENGTH x DATA_WIDTH  column vector; index 0 = oldest row, index KERNEL_LENGTH-1 = newest row.
REQ-013 out_eol  output  1  dout belongs to column ROW_LENGTH-1.
REQ-014 full_flag  output  1  all KERNEL_LENGTH-1 row stores are primed (STREAM state).

Function
REQ-015 Storage: KERNEL_LENGTH-1 row stores, ROW_LENGTH entries each, addressed by a shared column counter col_cnt.
REQ-016 Accept: in_valid && in_ready; in_ready = !clear && (!out_valid || out_ready).
REQ-017 On accept at column c: row store j (j>=1) loads row store j-1 at c; row store 0 loads din; the column vector {store[K-2][c] .. store[0][c], din}, read before update, is the candidate output.
REQ-018 col_cnt increments per accept, wraps ROW_LENGTH-1 -> 0; width clog2(ROW_LENGTH).
REQ-019 row_cnt increments on each col_cnt wrap, saturating at KERNEL_LENGTH-1.
REQ-020 States: FILL (row_cnt < KERNEL_LENGTH-1) and STREAM (row_cnt = KERNEL_LENGTH-1); FILL -> STREAM on the accept that wraps col_cnt with row_cnt = KERNEL_LENGTH-2; STREAM -> FILL only on clear or reset.
REQ-021 In FILL, accepts update storage but produce no output; in STREAM, every accept registers the candidate into dout, sets out_valid, and sets out_eol = (c == ROW_LENGTH-1).
REQ-022 Latency: one cycle from accept to out_valid; throughput one vector per cycle while out_ready is high.
REQ-023 Output hold: while out_valid && !out_ready, dout, out_eol and out_valid stay constant and in_ready is low.
REQ-024 out_valid clears after out_ready when no new STREAM accept occurs in the same cycle.
REQ-025 Simultaneous output take and STREAM accept: dout is replaced with no bubble.
REQ-026 clear: col_cnt, row_cnt, out_valid and out_eol reset to 0; state goes to FILL; row-store contents are unchanged and are not observable; clear overrides a concurrent in_valid.
REQ-027 full_flag = 1 exactly in STREAM.

Reset
REQ-028 rst high asynchronously forces out_valid=0, out_eol=0, full_flag=0, col_cnt=0, row_cnt=0, state FILL; in_ready reads 1 once rst and clear are low.
REQ-029 dout resets to all zeros; row stores are not reset.
REQ-030 Reset mid-frame discards the partial frame; the next accepted pixel is column 0 of row 0.

Configuration
REQ-031 Macro LINE_BUFFER_DEBUG_EN: when defined, extra outputs dbg_col_cnt (clog2(ROW_LENGTH) bits) and dbg_row_cnt (clog2(KERNEL_LENGTH) bits) mirror the internal counters combinationally; when undefined, these ports and all associated logic are absent and function is otherwise identical.

Verification (KERNEL_LENGTH=3, ROW_LENGTH=4, DATA_WIDTH=8)
REQ-032 Fill: stream pixels 0..7 with out_ready=1 -> out_valid stays 0, full_flag rises after pixel 7 is accepted.
REQ-033 Stream: continue with pixels 8..11 -> out_valid for 4 cycles, dout = {0,4,8},{1,5,9},{2,6,10},{3,7,11}, out_eol only on the last vector.
REQ-034 Backpressure: hold out_ready=0 after the first STREAM vector -> in_ready=0, dout held at {0,4,8}; release -> the remaining vectors arrive in order with none lost or duplicated.
REQ-035 Clear: assert clear during pixel 9 with in_valid=1 -> pixel not accepted, out_valid=0, full_flag=0; the next 8 pixels produce no output.
REQ-036 Async reset: assert rst between clock edges during STREAM -> out_valid, full_flag and out_eol drop immediately; the refill behaves as in REQ-032.
REQ-037 Debug build with LINE_BUFFER_DEBUG_EN: after 6 accepts -> dbg_col_cnt=2, dbg_row_cnt=1.
